// File: rtl/shift_pipe_pkg.sv
// rtl/shift_pipe_pkg.sv - shared shift-unit defines: op encodings and stage level split
//
// Purpose: op encodings shared with the ALU decoder, plus the helper that maps
//          logarithmic-shifter levels onto pipeline stages.
// Ports:   none (package).
package shift_pipe_pkg;

  typedef enum logic [1:0] {
    OP_SLL  = 2'b00,
    OP_SRL  = 2'b01,
    OP_SRA  = 2'b10,
    OP_ROTR = 2'b11
  } shift_op_e;

  localparam int OP_W = 2;

  // First shifter level handled by stage s. Level i lands in stage
  // floor(i*stages/shamt_w), so stage s starts at ceil(s*shamt_w/stages).
  function automatic int level_lo(int s, int stages, int shamt_w);
    return (s * shamt_w + stages - 1) / stages;
  endfunction

endpackage

// File: rtl/shift_pipe_if.sv
// rtl/shift_pipe_if.sv - valid/ready operation and result bundle of the shift unit
//
// Purpose: groups the input-operation and output-result handshakes.
// Ports:   in_valid/in_ready/in_op/in_data/in_shamt/in_tag  operation channel
//          out_valid/out_ready/out_result/out_tag/out_zero  result channel
//          master = producer/consumer side, slave = shift unit side.
interface shift_pipe_if #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH),
  parameter int TAG_W   = 5
);
  logic               in_valid;
  logic               in_ready;
  logic [1:0]         in_op;
  logic [WIDTH-1:0]   in_data;
  logic [SHAMT_W-1:0] in_shamt;
  logic [TAG_W-1:0]   in_tag;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_result;
  logic [TAG_W-1:0]   out_tag;
  logic               out_zero;

  modport master (
    output in_valid, in_op, in_data, in_shamt, in_tag, out_ready,
    input  in_ready, out_valid, out_result, out_tag, out_zero
  );

  modport slave (
    input  in_valid, in_op, in_data, in_shamt, in_tag, out_ready,
    output in_ready, out_valid, out_result, out_tag, out_zero
  );
endinterface

// File: rtl/shift_pipe_stage.sv
// rtl/shift_pipe_stage.sv - one registered stage of the pipelined logarithmic shifter
//
// Purpose: applies shifter levels LVL_LO..LVL_HI-1 to the incoming partial
//          value and registers it together with op, shift amount and tag.
// Ports:   clk, rst (async, active-high), flush (sync kill)
//          up_*  : valid/ready input from previous stage (or unit input)
//          dn_*  : valid/ready output to next stage (or unit output)
module shift_stage
  import shift_pipe_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5,
  parameter int TAG_W   = 5,
  parameter int LVL_LO  = 0,
  parameter int LVL_HI  = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               up_valid,
  output logic               up_ready,
  input  logic [1:0]         up_op,
  input  logic [WIDTH-1:0]   up_data,
  input  logic [SHAMT_W-1:0] up_shamt,
  input  logic [TAG_W-1:0]   up_tag,
  output logic               dn_valid,
  input  logic               dn_ready,
  output logic [1:0]         dn_op,
  output logic [WIDTH-1:0]   dn_data,
  output logic [SHAMT_W-1:0] dn_shamt,
  output logic [TAG_W-1:0]   dn_tag
);

  // Shift by a single power-of-two amount. Composing these per level gives
  // the full shift: SRA keeps the original sign in the MSB, so repeated
  // arithmetic steps still fill with in_data[WIDTH-1].
  function automatic logic [WIDTH-1:0] shift_level(shift_op_e op, logic [WIDTH-1:0] d, int n);
    logic [WIDTH-1:0] r;
    case (op)
      OP_SLL:  r = d << n;
      OP_SRL:  r = d >> n;
      OP_SRA:  r = $signed(d) >>> n;
      default: r = (d >> n) | (d << (WIDTH - n));
    endcase
    return r;
  endfunction

  logic [WIDTH-1:0] lvl [LVL_LO:LVL_HI];

  assign lvl[LVL_LO] = up_data;

  for (genvar g = LVL_LO; g < LVL_HI; g++) begin : g_level
    assign lvl[g+1] = up_shamt[g] ? shift_level(shift_op_e'(up_op), lvl[g], 2**g) : lvl[g];
  end

  logic               valid_q, valid_d;
  shift_op_e          op_q, op_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic [SHAMT_W-1:0] shamt_q, shamt_d;
  logic [TAG_W-1:0]   tag_q, tag_d;

  // Stage can take new contents when empty or when its contents move on.
  assign up_ready = !valid_q || dn_ready;

  always_comb begin
    valid_d = valid_q;
    op_d    = op_q;
    data_d  = data_q;
    shamt_d = shamt_q;
    tag_d   = tag_q;
    if (up_ready) begin
      valid_d = up_valid;
    end
    // Payload only changes on a real load so a stalled or drained stage
    // keeps its last value stable.
    if (up_ready && up_valid) begin
      op_d    = shift_op_e'(up_op);
      data_d  = lvl[LVL_HI];
      shamt_d = up_shamt;
      tag_d   = up_tag;
    end
    if (flush) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      op_q    <= OP_SLL;
      data_q  <= '0;
      shamt_q <= '0;
      tag_q   <= '0;
    end else begin
      valid_q <= valid_d;
      op_q    <= op_d;
      data_q  <= data_d;
      shamt_q <= shamt_d;
      tag_q   <= tag_d;
    end
  end

  assign dn_valid = valid_q;
  assign dn_op    = op_q;
  assign dn_data  = data_q;
  assign dn_shamt = shamt_q;
  assign dn_tag   = tag_q;

endmodule

// File: rtl/shift_pipe.sv
// rtl/shift_pipe.sv - pipelined shift/rotate unit with valid/ready handshakes
//
// Purpose: SLL/SRL/SRA/ROTR of a WIDTH-bit operand, logarithmic shifter split
//          over STAGES registered stages, sideband tag carried unchanged.
// Ports:   clk    rising-edge clock
//          rst    asynchronous active-high reset
//          flush  synchronous kill of all in-flight operations
//          bus    shift_pipe_if.slave: operation in, result out
module shift_pipe
  import shift_pipe_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH),
  parameter int STAGES  = 2,
  parameter int TAG_W   = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  shift_pipe_if.slave   bus
);

  // Index 0 is the unit input, index STAGES the unit output; element s+1 is
  // the registered output of stage s.
  logic               vld_s   [STAGES+1];
  logic               rdy_s   [STAGES+1];
  logic [1:0]         op_s    [STAGES+1];
  logic [WIDTH-1:0]   data_s  [STAGES+1];
  logic [SHAMT_W-1:0] shamt_s [STAGES+1];
  logic [TAG_W-1:0]   tag_s   [STAGES+1];

  assign vld_s[0]   = bus.in_valid;
  assign op_s[0]    = bus.in_op;
  assign data_s[0]  = bus.in_data;
  assign shamt_s[0] = bus.in_shamt;
  assign tag_s[0]   = bus.in_tag;

  // Anything presented during flush is refused; stage 0 would drop it anyway.
  assign bus.in_ready = rdy_s[0] && !flush;

  assign rdy_s[STAGES] = bus.out_ready;

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    shift_stage #(
      .WIDTH   (WIDTH),
      .SHAMT_W (SHAMT_W),
      .TAG_W   (TAG_W),
      .LVL_LO  (level_lo(s, STAGES, SHAMT_W)),
      .LVL_HI  (level_lo(s + 1, STAGES, SHAMT_W))
    ) u_stage (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .up_valid (vld_s[s]),
      .up_ready (rdy_s[s]),
      .up_op    (op_s[s]),
      .up_data  (data_s[s]),
      .up_shamt (shamt_s[s]),
      .up_tag   (tag_s[s]),
      .dn_valid (vld_s[s+1]),
      .dn_ready (rdy_s[s+1]),
      .dn_op    (op_s[s+1]),
      .dn_data  (data_s[s+1]),
      .dn_shamt (shamt_s[s+1]),
      .dn_tag   (tag_s[s+1])
    );
  end

  assign bus.out_valid  = vld_s[STAGES];
  assign bus.out_result = data_s[STAGES];
  assign bus.out_tag    = tag_s[STAGES];
  assign bus.out_zero   = (data_s[STAGES] == '0);

endmodule
